apb_slave_regs: RTL and testbench
=================================

# apb_slave_regs

APB completer that answers the transfers issued by the team's APB master. It holds a small register file of `DEPTH` 8-bit words, inserts a programmable number of wait states before asserting `pready`, and flags out-of-range accesses with `pslverr`. It sits on the `pclk` domain directly behind the master's `psel`/`penable`/`pwrite`/`paddr`/`pwdata` outputs and returns `prdata`/`pready`.

## Interface
- `DEPTH`, 16: number of 8-bit registers; valid addresses are 0..DEPTH-1, with DEPTH ≤ 256.
- `WAIT_CYCLES`, 2: wait states inserted in the access phase, range 0..15.
- `pclk` input 1: sole clock; everything updates on the rising edge.
- `prst_n` input 1: reset, asynchronous and active-low.
- `psel` input 1: completer selected.
- `penable` input 1: access phase.
- `pwrite` input 1: 1 means write, 0 means read.
- `paddr` input 8: byte address.
- `pwdata` input 8: write data.
- `prdata` output 8: read data; valid only while `pready`=1 and the transfer is a read, otherwise 0.
- `pready` output 1: transfer completes at the edge where `psel`, `penable` and `pready` are all 1.
- `pslverr` output 1: error, valid only while `pready`=1.

## Operation
- **States**
  - IDLE: `pready`=0.
  - WAIT: wait-state countdown.
  - READY: `pready`=1.
- **Setup capture (IDLE)**
  - At an edge sampling `psel`=1 and `penable`=0, latch `paddr`, `pwrite` and `pwdata`.
  - Set the error flag to (`paddr` ≥ DEPTH).
  - Load the 4-bit counter with WAIT_CYCLES.
  - Next state: WAIT if WAIT_CYCLES>0, else READY.
- **IDLE, other inputs**
  - `psel`=1 with `penable`=1 (no preceding setup) is a protocol violation.
  - It is ignored and the block stays in IDLE; no write and no `pready`.
- **WAIT**
  - The counter decrements each edge.
  - At the edge where the counter is 1, go to READY.
- **READY**
  - `pready`=1 and `pslverr` = latched error flag.
  - `prdata` = mem[latched addr] when the latched direction is read and there is no error, else 0.
- **Completion edge** (`psel`=1, `penable`=1, READY)
  - If write and no error: mem[latched addr] <= latched `pwdata`.
  - Next state: IDLE.
- **Back-to-back transfers**
  - The master's next setup cycle arrives while the block is in IDLE and is captured normally.
  - No dead cycle beyond the APB setup phase.
- **Abort**
  - If `psel`=0 while in WAIT or READY, return to IDLE with no write.
  - The register file is unchanged.
- **Error access**
  - No register is modified; `prdata`=0.
  - The wait states are still honoured.
- **Read timing**
  - Reads take their value from the latched address at READY time.
  - A write to the same address completed earlier is visible: read-after-write coherent.

## Timing
- **Reset**
  - On reset: state IDLE; counter, latches and error flag 0.
  - `pready`=0, `pslverr`=0, `prdata`=0.
  - All registers are cleared to 0x00.
- **Reset mid-transfer**
  - An assertion in WAIT or READY drops `pready` immediately (asynchronous) and discards the pending write.
- **Latency** (setup edge at cycle 0)
  - `pready` is high during cycle WAIT_CYCLES+1.
  - The transfer completes at the end of that cycle.
  - A transfer therefore occupies WAIT_CYCLES+2 `pclk` cycles.
- **Output decode**
  - `pready`, `pslverr` and `prdata` are decoded from registered state and latches only.
  - There is no combinational path from bus inputs to outputs.
- **Input changes during a transfer**
  - Changes to `paddr`, `pwrite` or `pwdata` after the setup edge have no effect.

## Structure
- Shared package `apb_pkg`:
  - state encoding: IDLE=0, WAIT=1, READY=2;
  - bus widths: `APB_AW`=8, `APB_DW`=8.
  - The same package is imported by the APB master.
- One sub-module, `apb_regfile`:
  - DEPTH×8 array with asynchronous clear, one write port and one combinational read port.
- The FSM, counter and decode live in the top level.

## Test plan
- **Write then read, WAIT_CYCLES=2.**
  - Stimulus: write 0xA5 to addr 0x03, then read 0x03.
  - Required: `pready` high 3 cycles after each setup edge; `prdata`=0xA5; `pslverr`=0.
- **Zero-wait, WAIT_CYCLES=0.**
  - Stimulus: write 0x3C to addr 0x0F, then read it.
  - Required: `pready` high in the first access cycle; read returns 0x3C.
- **Out-of-range address.**
  - Stimulus: write 0xFF to addr 0x10 (DEPTH=16), then read addr 0x10.
  - Required: `pslverr`=1 with `pready`; `prdata`=0; a read of addr 0x00 returns 0x00.
- **Abort.**
  - Stimulus: drop `psel` during WAIT of a write of 0x77 to addr 0x05.
  - Required: state returns to IDLE; a later read of 0x05 returns 0x00.
- **Mid-transfer reset.**
  - Stimulus: assert `prst_n`=0 asynchronously in READY of a write of 0x11 to addr 0x02.
  - Required: `pready` drops without waiting for an edge; a read of 0x02 after release returns 0x00.
- **Back-to-back and protocol violation.**
  - Stimulus: writes of 0x01 and 0x02 to addrs 0x00 and 0x01 with no idle cycle; then `psel`=`penable`=1 with no setup.
  - Required: both writes land; the violation yields no `pready`.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the completer FSM state encoding.
// Imported by both the APB master and the apb_slave_regs completer.
package apb_pkg;
  localparam int APB_AW = 8;
  localparam int APB_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_state_e;
endpackage

// File: rtl/apb_regfile.sv
// DEPTH x APB_DW register array.
// Ports: clk/rst_n (async active-low clear of every word), we/waddr/wdata
// single write port, raddr/rdata combinational read port (0 when
// raddr is outside the array).
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [APB_AW-1:0] waddr,
  input  logic [APB_DW-1:0] wdata,
  input  logic [APB_AW-1:0] raddr,
  output logic [APB_DW-1:0] rdata
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][APB_DW-1:0] mem;

  // The write enable is only raised for in-range addresses, so the
  // truncated index always lands inside the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < 9'(DEPTH)) rdata = mem[raddr[IW-1:0]];
  end
endmodule

// File: rtl/apb_slave_regs.sv
// APB completer fronting a small register file.
// Ports: pclk, prst_n (async active-low); APB requester side psel,
// penable, pwrite, paddr, pwdata; completer side prdata, pready, pslverr.
// Address/direction/data are latched at the setup edge; WAIT_CYCLES wait
// states follow before pready. All outputs decode from registered state.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  output logic [APB_DW-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);
  apb_state_e        state, state_nxt;
  logic [3:0]        cnt;
  logic [APB_AW-1:0] addr_q;
  logic [APB_DW-1:0] wdata_q;
  logic              wr_q;
  logic              err_q;
  logic [APB_DW-1:0] rd_data;

  logic setup, done, we;

  // A psel+penable seen in IDLE without a setup is ignored.
  assign setup = (state == ST_IDLE) && psel && !penable;
  assign done  = (state == ST_READY) && psel && penable;
  assign we    = done && wr_q && !err_q;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (setup) state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_READY;
      ST_WAIT:  if (!psel) state_nxt = ST_IDLE;
                else if (cnt == 4'd1) state_nxt = ST_READY;
      ST_READY: if (!psel || penable) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (setup) begin
      cnt     <= 4'(WAIT_CYCLES);
      addr_q  <= paddr;
      wdata_q <= pwdata;
      wr_q    <= pwrite;
      err_q   <= ({1'b0, paddr} >= 9'(DEPTH));
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  apb_regfile #(.DEPTH(DEPTH)) u_regfile (
    .clk   (pclk),
    .rst_n (prst_n),
    .we    (we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (addr_q),
    .rdata (rd_data)
  );

  assign pready  = (state == ST_READY);
  assign pslverr = pready && err_q;
  assign prdata  = (pready && !wr_q && !err_q) ? rd_data : '0;
endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: one instance with WAIT_CYCLES=2 (a)
// and one with WAIT_CYCLES=0 (b) sharing the bus except for psel.
module tb_apb_slave_regs;
  logic       pclk = 1'b0;
  logic       prst_n = 1'b0;
  logic       psel_a = 1'b0, psel_b = 1'b0;
  logic       penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = '0, pwdata = '0;
  logic [7:0] prdata_a, prdata_b;
  logic       pready_a, pready_b, pslverr_a, pslverr_b;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 pclk = ~pclk;

  apb_slave_regs #(.DEPTH(16), .WAIT_CYCLES(2)) dut_a (
    .pclk(pclk), .prst_n(prst_n), .psel(psel_a), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_slave_regs #(.DEPTH(16), .WAIT_CYCLES(0)) dut_b (
    .pclk(pclk), .prst_n(prst_n), .psel(psel_b), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  // One full transfer starting at a negedge; returns at the negedge after
  // the completion edge. b2b leaves psel up so the caller can chain a setup.
  // Address/data/direction are scrambled after setup to prove they are latched.
  task automatic xfer(input bit z, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] exp_rd,
                      input logic exp_err, input string nm, input bit b2b);
    int   w;
    logic rdy, err;
    logic [7:0] rd;
    w = z ? 0 : 2;
    psel_a = !z; psel_b = z; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1; pwrite = ~wr; paddr = ~a; pwdata = ~d;
    for (int c = 1; c <= w + 1; c++) begin
      if (c > 1) @(negedge pclk);
      rdy = z ? pready_b : pready_a;
      chk_cnt++;
      if (rdy !== (c == w + 1))
        $display("FAIL %s pready cycle %0d: got %b want %b", nm, c, rdy, (c == w + 1));
      else pass_cnt++;
    end
    err = z ? pslverr_b : pslverr_a;
    rd  = z ? prdata_b  : prdata_a;
    chk_cnt++;
    if (err !== exp_err) $display("FAIL %s pslverr: got %b want %b", nm, err, exp_err);
    else pass_cnt++;
    chk_cnt++;
    if (rd !== exp_rd) $display("FAIL %s prdata: got %h want %h", nm, rd, exp_rd);
    else pass_cnt++;
    @(negedge pclk);
    rdy = z ? pready_b : pready_a;
    chk_cnt++;
    if (rdy !== 1'b0) $display("FAIL %s pready after completion: got %b want 0", nm, rdy);
    else pass_cnt++;
    if (!b2b) begin
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++;
    if ({pready_a, pslverr_a, prdata_a} !== 10'h0)
      $display("FAIL reset_a: got rdy=%b err=%b rd=%h want 0", pready_a, pslverr_a, prdata_a);
    else pass_cnt++;
    chk_cnt++;
    if ({pready_b, pslverr_b, prdata_b} !== 10'h0)
      $display("FAIL reset_b: got rdy=%b err=%b rd=%h want 0", pready_b, pslverr_b, prdata_b);
    else pass_cnt++;
    @(negedge pclk); @(negedge pclk);
    prst_n = 1'b1;
    @(negedge pclk);
  endtask

  task automatic test_write_read();
    xfer(1'b0, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0, "wr3", 1'b0);
    xfer(1'b0, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0, "rd3", 1'b0);
  endtask

  task automatic test_zero_wait();
    xfer(1'b1, 1'b1, 8'h0F, 8'h3C, 8'h00, 1'b0, "z_wrF", 1'b0);
    xfer(1'b1, 1'b0, 8'h0F, 8'h00, 8'h3C, 1'b0, "z_rdF", 1'b0);
  endtask

  task automatic test_out_of_range();
    xfer(1'b0, 1'b1, 8'h10, 8'hFF, 8'h00, 1'b1, "oor_wr", 1'b0);
    xfer(1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, "oor_rd", 1'b0);
    xfer(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "oor_rd0", 1'b0);
  endtask

  task automatic test_back_to_back();
    xfer(1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 1'b0, "b2b_w0", 1'b1);
    xfer(1'b0, 1'b1, 8'h01, 8'h02, 8'h00, 1'b0, "b2b_w1", 1'b0);
    xfer(1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, "b2b_r0", 1'b0);
    xfer(1'b0, 1'b0, 8'h01, 8'h00, 8'h02, 1'b0, "b2b_r1", 1'b0);
  endtask

  task automatic test_violation();
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk_cnt++;
      if (pready_a !== 1'b0) $display("FAIL viol pready %0d: got %b want 0", i, pready_a);
      else pass_cnt++;
    end
    psel_a = 1'b0; penable = 1'b0;
    @(negedge pclk);
    xfer(1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0, "viol_rd0", 1'b0);
  endtask

  task automatic test_abort();
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h77;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk);
    chk_cnt++;
    if (pready_a !== 1'b0) $display("FAIL abort pready in wait: got %b want 0", pready_a);
    else pass_cnt++;
    psel_a = 1'b0; penable = 1'b0;
    @(negedge pclk); @(negedge pclk);
    chk_cnt++;
    if (pready_a !== 1'b0) $display("FAIL abort pready after: got %b want 0", pready_a);
    else pass_cnt++;
    xfer(1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0, "abort_rd5", 1'b0);
  endtask

  task automatic test_mid_reset();
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h11;
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk); @(negedge pclk);
    chk_cnt++;
    if (pready_a !== 1'b1) $display("FAIL mrst pready before: got %b want 1", pready_a);
    else pass_cnt++;
    #2 prst_n = 1'b0;
    #1;
    chk_cnt++;
    if (pready_a !== 1'b0) $display("FAIL mrst pready async drop: got %b want 0", pready_a);
    else pass_cnt++;
    psel_a = 1'b0; penable = 1'b0;
    @(negedge pclk); prst_n = 1'b1;
    @(negedge pclk);
    xfer(1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, "mrst_rd2", 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_out_of_range();
    test_back_to_back();
    test_violation();
    test_abort();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
